// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between IF and
// memory_controller. Hits answer in one cycle; misses refill one 32-bit word.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global stall), roll_back
//   fetch_start, pc -> busy, finish_fetch, instruction_out, instruction_pc_out
//   mem_req, mem_addr -> memory_controller; mem_done, mem_data <- memory_controller
// Optional feature: define ICACHE_STATS_EN to add hit_cnt/miss_cnt outputs.
module icache #(
  parameter int INDEX_W = 6,
  parameter int ADDR_W  = 18
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        fetch_start,
  input  logic [31:0] pc,
  output logic        busy,
  output logic        finish_fetch,
  output logic [31:0] instruction_out,
  output logic [31:0] instruction_pc_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_W;
  localparam int TAG_W = ADDR_W - INDEX_W - 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  logic [31:0] r_req_pc;
  logic        r_drop;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_fidx;
  logic [TAG_W-1:0]   w_ftag;
  logic               w_hit;
  logic               w_accept;
  logic               w_fill;

  assign w_idx  = pc[INDEX_W+1:2];
  assign w_tag  = pc[ADDR_W-1:INDEX_W+2];
  assign w_fidx = r_req_pc[INDEX_W+1:2];
  assign w_ftag = r_req_pc[ADDR_W-1:INDEX_W+2];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  // A fetch paired with roll_back is discarded before lookup.
  assign w_accept = rdy_in && fetch_start && !roll_back
                  && (r_state == S_IDLE);
  // mem_done is only consumed while not stalled.
  assign w_fill   = rdy_in && mem_done && (r_state == S_MISS);

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state <= S_IDLE;
    end else if (rdy_in) begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept && !w_hit) w_next = S_MISS;
      S_MISS: if (mem_done) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state; mem_req falls with reset at once.
  always_comb begin
    busy    = (r_state != S_IDLE);
    mem_req = (r_state == S_MISS);
  end

  // Response, request and valid-bit registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_valid            <= '0;
      r_req_pc           <= '0;
      r_drop             <= 1'b0;
      mem_addr           <= '0;
      finish_fetch       <= 1'b0;
      instruction_out    <= '0;
      instruction_pc_out <= '0;
    end else if (rdy_in) begin
      finish_fetch <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_req_pc <= pc;
            if (w_hit) begin
              finish_fetch       <= 1'b1;
              instruction_out    <= r_data[w_idx];
              instruction_pc_out <= pc;
            end else begin
              mem_addr <= {pc[31:2], 2'b00};
            end
          end
        end
        S_MISS: begin
          if (roll_back) r_drop <= 1'b1;
          if (mem_done) begin
            r_valid[w_fidx]    <= 1'b1;
            finish_fetch       <= !(r_drop || roll_back);
            instruction_out    <= mem_data;
            instruction_pc_out <= r_req_pc;
          end
        end
        S_RESP: r_drop <= 1'b0;
        default: ;
      endcase
    end
  end

  // Tag/data storage carries no reset; valid bits gate it.
  always_ff @(posedge clk_in) begin
    if (w_fill) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  // Lookups are counted at acceptance, even if the answer is later dropped.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (w_accept) begin
      if (w_hit) hit_cnt  <= hit_cnt + 32'd1;
      else       miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: directed scenarios plus randomized traffic for icache,
// checked every cycle against a transaction-level cache model.
`timescale 1ns/1ps
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        roll_back;
  logic        fetch_start;
  logic [31:0] pc;
  logic        busy;
  logic        finish_fetch;
  logic [31:0] instruction_out;
  logic [31:0] instruction_pc_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done;
  logic [31:0] mem_data;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk_in             (clk_in),
    .rst_in             (rst_in),
    .rdy_in             (rdy_in),
    .roll_back          (roll_back),
    .fetch_start        (fetch_start),
    .pc                 (pc),
    .busy               (busy),
    .finish_fetch       (finish_fetch),
    .instruction_out    (instruction_out),
    .instruction_pc_out (instruction_pc_out),
    .mem_req            (mem_req),
    .mem_addr           (mem_addr),
    .mem_done           (mem_done),
    .mem_data           (mem_data)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt            (hit_cnt),
    .miss_cnt           (miss_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  int tests;
  int fails;

  // Model: cache contents keyed by line index, holding the word address
  // pc[17:2] that owns the line and the stored word.
  logic [15:0] line_of [int];
  logic [31:0] word_of [int];
  int          m_phase;   // 0 idle, 1 waiting for memory, 2 delivering
  logic [31:0] m_pc;
  bit          m_drop;
  logic        e_fin;
  logic [31:0] e_ins;
  logic [31:0] e_ipc;
  logic [31:0] e_addr;
  int unsigned e_hits;
  int unsigned e_miss;
  int          m_wait;
  int          lat;
  int          n_fin;
  int          n_req;
  logic [31:0] last_ins;
  logic [31:0] last_ipc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    line_of.delete();
    word_of.delete();
    m_phase = 0;
    m_drop  = 0;
    m_pc    = '0;
    e_fin   = 1'b0;
    e_ins   = '0;
    e_ipc   = '0;
    e_addr  = '0;
    e_hits  = 0;
    e_miss  = 0;
    m_wait  = 0;
    mem_done = 1'b0;
  endtask

  // Applied after each rising edge, using the inputs the DUT just sampled.
  task automatic model_edge();
    int idx;
    if (!rdy_in) return;
    case (m_phase)
      0: begin
        e_fin = 1'b0;
        if (fetch_start && !roll_back) begin
          idx = int'(pc[7:2]);
          if (line_of.exists(idx) && line_of[idx] == pc[17:2]) begin
            e_fin = 1'b1;
            e_ins = word_of[idx];
            e_ipc = pc;
            e_hits++;
          end else begin
            m_phase = 1;
            m_pc    = pc;
            m_drop  = 0;
            e_addr  = {pc[31:2], 2'b00};
            m_wait  = lat;
            e_miss++;
          end
        end
      end
      1: begin
        if (roll_back) m_drop = 1;
        if (mem_done) begin
          idx = int'(m_pc[7:2]);
          line_of[idx] = m_pc[17:2];
          word_of[idx] = mem_data;
          e_fin    = !m_drop;
          e_ins    = mem_data;
          e_ipc    = m_pc;
          m_phase  = 2;
          mem_done = 1'b0;
        end
      end
      default: begin
        e_fin   = 1'b0;
        m_phase = 0;
      end
    endcase
  endtask

  task automatic compare();
    chk1("busy", busy, m_phase != 0);
    chk1("mem_req", mem_req, m_phase == 1);
    chk32("mem_addr", mem_addr, e_addr);
    chk1("finish_fetch", finish_fetch, e_fin);
    if (e_fin) begin
      chk32("instruction_out", instruction_out, e_ins);
      chk32("instruction_pc_out", instruction_pc_out, e_ipc);
    end
`ifdef ICACHE_STATS_EN
    chk32("hit_cnt", hit_cnt, e_hits);
    chk32("miss_cnt", miss_cnt, e_miss);
`endif
    if (finish_fetch) begin
      n_fin++;
      last_ins = instruction_out;
      last_ipc = instruction_pc_out;
    end
    if (mem_req) n_req++;
  endtask

  task automatic step(input bit fs, input logic [31:0] p,
                      input bit rb, input bit rdy);
    fetch_start = fs;
    pc          = p;
    roll_back   = rb;
    rdy_in      = rdy;
    if (m_phase == 1 && !mem_done) begin
      if (m_wait > 0) m_wait--;
      if (m_wait == 0) begin
        mem_done = 1'b1;
        mem_data = mem_word(e_addr);
      end else begin
        mem_data = $urandom;
      end
    end
    @(posedge clk_in);
    #1;
    model_edge();
    @(negedge clk_in);
    compare();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (m_phase != 0 && k < 40) begin
      step(0, 32'h0, 0, 1);
      k++;
    end
    tests++;
    if (m_phase != 0) begin
      fails++;
      $display("FAIL drain: phase %0d after %0d cycles, required idle", m_phase, k);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_in = 1'b0;
    rdy_in = 1'b1;
    roll_back = 1'b0;
    fetch_start = 1'b0;
    pc = '0;
    mem_data = '0;
    lat = 3;
    n_fin = 0;
    n_req = 0;
    last_ins = '0;
    last_ipc = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    compare();
    chk32("rst_instruction_out", instruction_out, 32'h0);
    chk32("rst_instruction_pc_out", instruction_pc_out, 32'h0);
    rst_in = 1'b1;

    // Cold miss at 0x0, memory answers after 3 cycles.
    n_req = 0;
    n_fin = 0;
    step(1, 32'h0, 0, 1);
    chk32("t1_mem_addr", mem_addr, 32'h0);
    drain();
    chk32("t1_req_cycles", n_req, 3);
    chk32("t1_fin_count", n_fin, 1);
    chk32("t1_ins", last_ins, 32'h13);
    chk32("t1_ipc", last_ipc, 32'h0);

    // Refetch hits at t+1, then four back-to-back hits.
    n_req = 0;
    n_fin = 0;
    step(1, 32'h0, 0, 1);
    chk1("t2_hit_pulse", finish_fetch, 1'b1);
    chk32("t2_hit_ins", instruction_out, 32'h13);
    repeat (4) step(1, 32'h0, 0, 1);
    step(0, 32'h0, 0, 1);
    chk32("t2_fin_count", n_fin, 5);
    chk32("t2_req_cycles", n_req, 0);

    // Alias: 0x100 shares the index of 0x0.
    step(1, 32'h100, 0, 1);
    chk1("t3_alias_miss", mem_req, 1'b1);
    drain();
    step(1, 32'h0, 0, 1);
    chk1("t3_refetch_miss", mem_req, 1'b1);
    drain();

    // roll_back one cycle into a miss: no response, line still filled.
    n_fin = 0;
    step(1, 32'h40, 0, 1);
    step(0, 32'h0, 1, 1);
    drain();
    chk32("t4_no_fin", n_fin, 0);
    step(1, 32'h40, 0, 1);
    chk1("t4_hit_after_drop", finish_fetch, 1'b1);
    chk32("t4_hit_pc", instruction_pc_out, 32'h40);

    // Stall with mem_done pending.
    lat = 1;
    step(1, 32'h80, 0, 1);
    repeat (5) step(0, 32'h0, 0, 0);
    chk1("t5_still_req", mem_req, 1'b1);
    chk1("t5_no_fin", finish_fetch, 1'b0);
    step(0, 32'h0, 0, 1);
    chk1("t5_resp", finish_fetch, 1'b1);
    chk32("t5_resp_pc", instruction_pc_out, 32'h80);
    drain();
    step(1, 32'h80, 0, 1);
    step(0, 32'h0, 0, 0);
    chk1("t5_fin_held", finish_fetch, 1'b1);

    // Async reset in the middle of a miss.
    lat = 4;
    step(1, 32'h200, 0, 1);
    step(0, 32'h0, 0, 1);
    #2;
    rst_in = 1'b0;
    #1;
    chk1("t6_req_drop", mem_req, 1'b0);
    chk1("t6_busy_drop", busy, 1'b0);
`ifdef ICACHE_STATS_EN
    chk32("t6_hit_cnt_rst", hit_cnt, 32'h0);
    chk32("t6_miss_cnt_rst", miss_cnt, 32'h0);
`endif
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    lat = 2;
    step(1, 32'h0, 0, 1);
    chk1("t6_invalid_after_rst", mem_req, 1'b1);
    drain();
    step(1, 32'h0, 0, 1);
    step(1, 32'h0, 0, 1);
    step(1, 32'h100, 0, 1);
    drain();
`ifdef ICACHE_STATS_EN
    chk32("t7_hit_cnt", hit_cnt, 32'd2);
    chk32("t7_miss_cnt", miss_cnt, 32'd2);
`endif

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 3000; i++) begin
      bit          fs;
      bit          rb;
      bit          rdy;
      logic [31:0] p;
      fs  = (m_phase == 0) && ($urandom_range(0, 1) == 1);
      rb  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 9) != 0);
      p = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 15) == 0) p = p | ($urandom << 18);
      if (m_phase == 0) lat = $urandom_range(1, 4);
      step(fs, p, rb, rdy);
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
